// File: rtl/battle_pkg.sv
// ============================================================================
// Module      : battle_pkg
// Description : Shared types and constants for the battle turn scheduler:
//               FSM state encoding, trainer identifiers, default widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package battle_pkg;

    // Default datapath widths
    localparam int HP_W_DEFAULT   = 8;
    localparam int SPD_W_DEFAULT  = 8;
    localparam int TURN_W_DEFAULT = 8;

    // Trainer identifiers as used on calc_active_trainer / calc_target
    localparam logic TRAINER_P  = 1'b0;
    localparam logic TRAINER_AI = 1'b1;

    // Turn sequencing states
    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_WAIT_MOVES = 4'd1,
        S_ORDER      = 4'd2,
        S_CALC1      = 4'd3,
        S_APPLY1     = 4'd4,
        S_CALC2      = 4'd5,
        S_APPLY2     = 4'd6,
        S_VICTORY    = 4'd7,
        S_LOSS       = 4'd8
    } state_t;

endpackage

`default_nettype wire

// File: rtl/battle_turn_scheduler_hp_sat_sub.sv
// ============================================================================
// Module      : hp_sat_sub
// Description : Combinational saturating subtract, HP minus damage, floored
//               at zero so a large hit can never wrap HP around.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hp_sat_sub #(
    parameter int HP_W = 8
) (
    input  logic [HP_W-1:0] hp_i,
    input  logic [HP_W-1:0] dmg_i,
    output logic [HP_W-1:0] res_o
);

    assign res_o = (hp_i > dmg_i) ? (hp_i - dmg_i) : '0;

endmodule

`default_nettype wire

// File: rtl/battle_turn_scheduler.sv
// ============================================================================
// Module      : battle_turn_scheduler
// Description : Sequences one battle turn: orders attackers by speed (with an
//               alternating tie-break), shares the damage unit through a
//               start/done handshake, applies saturating damage to the HP
//               registers and declares victory or loss.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module battle_turn_scheduler
    import battle_pkg::*;
#(
    parameter int HP_W   = HP_W_DEFAULT,
    parameter int SPD_W  = SPD_W_DEFAULT,
    parameter int TURN_W = TURN_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_hp,
    input  logic [HP_W-1:0]   p_hp_init,
    input  logic [HP_W-1:0]   ai_hp_init,
    input  logic              go,
    input  logic              p_move_valid,
    input  logic              ai_move_valid,
    input  logic [SPD_W-1:0]  p_speed,
    input  logic [SPD_W-1:0]  ai_speed,
    output logic              calc_start,
    output logic              calc_active_trainer,
    output logic              calc_target,
    input  logic              calc_done,
    input  logic [HP_W-1:0]   dmg_in,
    output logic [HP_W-1:0]   p_hp,
    output logic [HP_W-1:0]   ai_hp,
    output logic              busy,
    output logic              victory,
    output logic              loss,
    output logic [TURN_W-1:0] turn_count
);

    state_t            state_q;
    logic [HP_W-1:0]   p_hp_q;
    logic [HP_W-1:0]   ai_hp_q;
    logic [HP_W-1:0]   dmg_q;
    logic              tie_bit_q;
    logic              first_q;
    logic              calc_start_q;
    logic              active_q;
    logic              target_q;
    logic              busy_q;
    logic              victory_q;
    logic              loss_q;
    logic [TURN_W-1:0] turn_q;

    logic [HP_W-1:0]   p_sub_d;
    logic [HP_W-1:0]   ai_sub_d;
    logic [HP_W-1:0]   p_hp_d;
    logic [HP_W-1:0]   ai_hp_d;
    logic              first_d;

    // One subtractor per HP register; both always see the captured damage
    hp_sat_sub #(.HP_W(HP_W)) u_p_sub (
        .hp_i  (p_hp_q),
        .dmg_i (dmg_q),
        .res_o (p_sub_d)
    );

    hp_sat_sub #(.HP_W(HP_W)) u_ai_sub (
        .hp_i  (ai_hp_q),
        .dmg_i (dmg_q),
        .res_o (ai_sub_d)
    );

    // Post-apply HP values and speed-based attack order
    always_comb begin
        p_hp_d  = (target_q == TRAINER_P)  ? p_sub_d  : p_hp_q;
        ai_hp_d = (target_q == TRAINER_AI) ? ai_sub_d : ai_hp_q;
        if (p_speed > ai_speed) begin
            first_d = TRAINER_P;
        end else if (ai_speed > p_speed) begin
            first_d = TRAINER_AI;
        end else begin
            first_d = tie_bit_q;
        end
    end

    // Turn FSM with all outputs registered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            p_hp_q       <= '0;
            ai_hp_q      <= '0;
            dmg_q        <= '0;
            tie_bit_q    <= 1'b0;
            first_q      <= TRAINER_P;
            calc_start_q <= 1'b0;
            active_q     <= 1'b0;
            target_q     <= 1'b0;
            busy_q       <= 1'b0;
            victory_q    <= 1'b0;
            loss_q       <= 1'b0;
            turn_q       <= '0;
        end else begin
            calc_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (load_hp) begin
                        p_hp_q  <= p_hp_init;
                        ai_hp_q <= ai_hp_init;
                        turn_q  <= '0;
                    end else if (go && (p_hp_q != '0) && (ai_hp_q != '0)) begin
                        state_q <= S_WAIT_MOVES;
                        busy_q  <= 1'b1;
                    end
                end
                S_WAIT_MOVES: begin
                    if (p_move_valid && ai_move_valid) begin
                        state_q <= S_ORDER;
                    end
                end
                S_ORDER: begin
                    first_q      <= first_d;
                    active_q     <= first_d;
                    target_q     <= ~first_d;
                    calc_start_q <= 1'b1;
                    state_q      <= S_CALC1;
                    if (p_speed == ai_speed) begin
                        tie_bit_q <= ~tie_bit_q;
                    end
                end
                S_CALC1, S_CALC2: begin
                    if (calc_done) begin
                        dmg_q   <= dmg_in;
                        state_q <= (state_q == S_CALC1) ? S_APPLY1 : S_APPLY2;
                    end
                end
                S_APPLY1, S_APPLY2: begin
                    p_hp_q  <= p_hp_d;
                    ai_hp_q <= ai_hp_d;
                    // A KO ends the turn at once, so a fainted Pokemon never attacks
                    if (ai_hp_d == '0) begin
                        state_q   <= S_VICTORY;
                        busy_q    <= 1'b0;
                        victory_q <= 1'b1;
                    end else if (p_hp_d == '0) begin
                        state_q <= S_LOSS;
                        busy_q  <= 1'b0;
                        loss_q  <= 1'b1;
                    end else if (state_q == S_APPLY1) begin
                        state_q      <= S_CALC2;
                        calc_start_q <= 1'b1;
                        active_q     <= ~first_q;
                        target_q     <= first_q;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        if (turn_q != '1) begin
                            turn_q <= turn_q + {{(TURN_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                S_VICTORY, S_LOSS: begin
                    if (load_hp) begin
                        p_hp_q    <= p_hp_init;
                        ai_hp_q   <= ai_hp_init;
                        turn_q    <= '0;
                        victory_q <= 1'b0;
                        loss_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign calc_start          = calc_start_q;
    assign calc_active_trainer = active_q;
    assign calc_target         = target_q;
    assign p_hp                = p_hp_q;
    assign ai_hp               = ai_hp_q;
    assign busy                = busy_q;
    assign victory             = victory_q;
    assign loss                = loss_q;
    assign turn_count          = turn_q;

endmodule

`default_nettype wire

// File: tb/tb_battle_turn_scheduler.sv
// ============================================================================
// Module      : tb_battle_turn_scheduler
// Description : Self-checking bench for battle_turn_scheduler. Expected
//               attacker/target pairs are queued when a turn is launched and
//               popped whenever the DUT issues calc_start.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_battle_turn_scheduler;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       load_hp = 1'b0;
    logic [7:0] p_hp_init = '0;
    logic [7:0] ai_hp_init = '0;
    logic       go = 1'b0;
    logic       p_move_valid = 1'b0;
    logic       ai_move_valid = 1'b0;
    logic [7:0] p_speed = '0;
    logic [7:0] ai_speed = '0;
    logic       calc_start;
    logic       calc_active_trainer;
    logic       calc_target;
    logic       calc_done = 1'b0;
    logic [7:0] dmg_in = '0;
    logic [7:0] p_hp;
    logic [7:0] ai_hp;
    logic       busy;
    logic       victory;
    logic       loss;
    logic [7:0] turn_count;

    typedef struct packed {
        logic active;
        logic target;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    battle_turn_scheduler #(.HP_W(8), .SPD_W(8), .TURN_W(8)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .load_hp             (load_hp),
        .p_hp_init           (p_hp_init),
        .ai_hp_init          (ai_hp_init),
        .go                  (go),
        .p_move_valid        (p_move_valid),
        .ai_move_valid       (ai_move_valid),
        .p_speed             (p_speed),
        .ai_speed            (ai_speed),
        .calc_start          (calc_start),
        .calc_active_trainer (calc_active_trainer),
        .calc_target         (calc_target),
        .calc_done           (calc_done),
        .dmg_in              (dmg_in),
        .p_hp                (p_hp),
        .ai_hp               (ai_hp),
        .busy                (busy),
        .victory             (victory),
        .loss                (loss),
        .turn_count          (turn_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every calc_start must match the next queued attacker/target
    always @(negedge clk) begin
        if (reset_n && calc_start) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_calc_start", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_val("calc_active", {31'd0, calc_active_trainer}, {31'd0, e.active});
                check_val("calc_target", {31'd0, calc_target}, {31'd0, e.target});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic load(input logic [7:0] p, input logic [7:0] a);
        p_hp_init  = p;
        ai_hp_init = a;
        load_hp    = 1'b1;
        tick();
        load_hp    = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (calc_start) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check_val("calc_start_timeout", 32'd0, 32'd1);
    endtask

    // Answer the next damage request after 'delay' cycles, then let APPLY finish
    task automatic serve_calc(input logic [7:0] dmg, input int delay);
        bit ok;
        wait_start(ok);
        if (ok) begin
            repeat (delay) tick();
            calc_done = 1'b1;
            dmg_in    = dmg;
            tick();
            calc_done = 1'b0;
            dmg_in    = '0;
            tick();
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check_val({pfx, "_calc_start"}, {31'd0, calc_start}, 32'd0);
        check_val({pfx, "_active"},     {31'd0, calc_active_trainer}, 32'd0);
        check_val({pfx, "_target"},     {31'd0, calc_target}, 32'd0);
        check_val({pfx, "_p_hp"},       {24'd0, p_hp}, 32'd0);
        check_val({pfx, "_ai_hp"},      {24'd0, ai_hp}, 32'd0);
        check_val({pfx, "_busy"},       {31'd0, busy}, 32'd0);
        check_val({pfx, "_victory"},    {31'd0, victory}, 32'd0);
        check_val({pfx, "_loss"},       {31'd0, loss}, 32'd0);
        check_val({pfx, "_turn"},       {24'd0, turn_count}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  ok;

        // Reset state
        repeat (2) tick();
        check_all_zero("reset");
        reset_n = 1'b1;
        tick();

        // go with zero HP is ignored
        p_move_valid = 1'b1;
        ai_move_valid = 1'b1;
        pulse_go();
        repeat (4) tick();
        check_val("go_zero_hp_busy", {31'd0, busy}, 32'd0);

        // Turn 1: player faster, 3-cycle latency, damage 15 then 12
        load(8'd50, 8'd40);
        check_val("load_p_hp", {24'd0, p_hp}, 32'd50);
        check_val("load_ai_hp", {24'd0, ai_hp}, 32'd40);
        p_speed  = 8'd20;
        ai_speed = 8'd10;
        exp_q.push_back('{active: 1'b0, target: 1'b1});
        exp_q.push_back('{active: 1'b1, target: 1'b0});
        pulse_go();
        lat = 1;
        for (int i = 0; i < 10; i++) begin
            if (calc_start) break;
            tick();
            lat++;
        end
        check_val("go_to_calc_latency", lat, 32'd3);
        serve_calc(8'd15, 1);
        check_val("t1_ai_hp", {24'd0, ai_hp}, 32'd25);
        check_val("t1_p_hp_mid", {24'd0, p_hp}, 32'd50);
        serve_calc(8'd12, 0);
        check_val("t1_p_hp", {24'd0, p_hp}, 32'd38);
        check_val("t1_turn", {24'd0, turn_count}, 32'd1);
        check_val("t1_busy", {31'd0, busy}, 32'd0);

        // AI faster, KOs player: loss, no second half
        load(8'd10, 8'd30);
        p_speed  = 8'd5;
        ai_speed = 8'd9;
        exp_q.push_back('{active: 1'b1, target: 1'b0});
        pulse_go();
        serve_calc(8'd10, 2);
        check_val("ko_p_hp", {24'd0, p_hp}, 32'd0);
        check_val("ko_ai_hp", {24'd0, ai_hp}, 32'd30);
        check_val("ko_loss", {31'd0, loss}, 32'd1);
        check_val("ko_busy", {31'd0, busy}, 32'd0);
        repeat (4) tick();
        pulse_go();
        repeat (3) tick();
        check_val("loss_go_busy", {31'd0, busy}, 32'd0);
        check_val("loss_hold", {31'd0, loss}, 32'd1);
        load(8'd100, 8'd100);
        check_val("loss_clear", {31'd0, loss}, 32'd0);
        check_val("reload_p_hp", {24'd0, p_hp}, 32'd100);

        // Equal speeds: player first, then AI first; moves held off at first
        p_speed  = 8'd10;
        ai_speed = 8'd10;
        p_move_valid = 1'b0;
        exp_q.push_back('{active: 1'b0, target: 1'b1});
        exp_q.push_back('{active: 1'b1, target: 0});
        pulse_go();
        repeat (2) tick();
        pulse_go();
        repeat (2) tick();
        check_val("wait_moves_busy", {31'd0, busy}, 32'd1);
        p_move_valid = 1'b1;
        serve_calc(8'd5, 0);
        serve_calc(8'd5, 0);
        check_val("tieA_p_hp", {24'd0, p_hp}, 32'd95);
        check_val("tieA_ai_hp", {24'd0, ai_hp}, 32'd95);
        exp_q.push_back('{active: 1'b1, target: 1'b0});
        exp_q.push_back('{active: 1'b0, target: 1'b1});
        pulse_go();
        serve_calc(8'd5, 1);
        serve_calc(8'd5, 0);
        check_val("tieB_p_hp", {24'd0, p_hp}, 32'd90);
        check_val("tieB_ai_hp", {24'd0, ai_hp}, 32'd90);
        check_val("tieB_turn", {24'd0, turn_count}, 32'd2);

        // Overkill saturates AI HP at zero: victory
        load(8'd50, 8'd7);
        p_speed  = 8'd20;
        ai_speed = 8'd10;
        exp_q.push_back('{active: 1'b0, target: 1'b1});
        pulse_go();
        serve_calc(8'd200, 0);
        check_val("sat_ai_hp", {24'd0, ai_hp}, 32'd0);
        check_val("sat_p_hp", {24'd0, p_hp}, 32'd50);
        check_val("victory_set", {31'd0, victory}, 32'd1);
        pulse_go();
        repeat (3) tick();
        check_val("victory_go_busy", {31'd0, busy}, 32'd0);
        check_val("victory_hold", {31'd0, victory}, 32'd1);
        load(8'd60, 8'd60);
        check_val("victory_clear", {31'd0, victory}, 32'd0);
        check_val("reload_turn", {24'd0, turn_count}, 32'd0);
        pulse_go();
        check_val("idle_after_load", {31'd0, busy}, 32'd1);

        // Asynchronous reset while in the second calculation
        exp_q.push_back('{active: 1'b0, target: 1'b1});
        exp_q.push_back('{active: 1'b1, target: 1'b0});
        serve_calc(8'd10, 0);
        check_val("rst_pre_ai_hp", {24'd0, ai_hp}, 32'd50);
        wait_start(ok);
        #6;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        calc_done = 1'b1;
        dmg_in    = 8'd50;
        tick();
        calc_done = 1'b0;
        dmg_in    = '0;
        repeat (3) tick();
        check_val("post_rst_p_hp", {24'd0, p_hp}, 32'd0);
        check_val("post_rst_ai_hp", {24'd0, ai_hp}, 32'd0);
        check_val("post_rst_busy", {31'd0, busy}, 32'd0);
        check_val("queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
